// File: rtl/exe_stage_pkg.sv
// Shared encodings for the execute stage: ALU op codes, operand selects,
// writeback-source default, reset constants and divider FSM states.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD   = 4'd0,
    ALU_OP_SUB   = 4'd1,
    ALU_OP_AND   = 4'd2,
    ALU_OP_OR    = 4'd3,
    ALU_OP_XOR   = 4'd4,
    ALU_OP_NOR   = 4'd5,
    ALU_OP_SLL   = 4'd6,
    ALU_OP_SRL   = 4'd7,
    ALU_OP_SRA   = 4'd8,
    ALU_OP_SLT   = 4'd9,
    ALU_OP_SLTU  = 4'd10,
    ALU_OP_LUI   = 4'd11,
    ALU_OP_DIVU  = 4'd12,
    ALU_OP_REMU  = 4'd13,
    ALU_OP_PASSB = 4'd14,
    ALU_OP_NOP   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    OPND1_REG   = 2'd0,
    OPND1_SA    = 2'd1,
    OPND1_ZERO  = 2'd2,
    OPND1_ZERO3 = 2'd3
  } opnd1_sel_e;

  typedef enum logic [1:0] {
    OPND2_REG     = 2'd0,
    OPND2_EXT     = 2'd1,
    OPND2_SIXTEEN = 2'd2,
    OPND2_ZERO    = 2'd3
  } opnd2_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [1:0]  WDATA_SRC_DEFAULT = 2'd0;
  localparam logic [31:0] INIT_32           = 32'd0;
  localparam logic [4:0]  INIT_5            = 5'd0;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

endpackage

// File: rtl/exe_stage_div.sv
// Iterative unsigned restoring divider: one shift-subtract step per cycle,
// DATA_W steps, then a single DONE cycle with quotient/remainder valid.
module div_iter_u
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        state, next_state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] quo, rem, dvs;
  logic [DATA_W:0]   shifted, diff;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: accept in IDLE, iterate DATA_W times, one DONE cycle.
  // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      DIV_IDLE: if (start) next_state = DIV_BUSY;
      DIV_BUSY: if (count == CNT_W'(DATA_W - 1)) next_state = DIV_DONE;
      DIV_DONE: next_state = DIV_IDLE;
      default:  next_state = DIV_IDLE;
    endcase
  end

  // Restoring step: shift next dividend bit into the partial remainder and
  // keep the subtraction only when it does not go negative. A zero divisor
  // naturally yields all-ones quotient and remainder = dividend.
  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs};

  // Divider datapath: load on accept, step while BUSY.
  // NOTE: datapath registers are reset too so a reset mid-divide leaves no stale result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      count <= '0;
    end else if (state == DIV_IDLE && start) begin
      quo   <= dividend;
      rem   <= '0;
      dvs   <= divisor;
      count <= '0;
    end else if (state == DIV_BUSY) begin
      rem   <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      quo   <= {quo[DATA_W-2:0], ~diff[DATA_W]};
      count <= count + 1'b1;
    end
  end

  assign busy      = (state != DIV_IDLE);
  assign done      = (state == DIV_DONE);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand muxes, combinational ALU, divide capture and the
// EXE/MEM output registers. Stalls upstream while a divide is in flight.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alu_op_in,
  input  logic [1:0]        ALUopnd1src_in,
  input  logic [1:0]        ALUopnd2src_in,
  input  logic [1:0]        WriteDataSrc_in,
  input  logic              DataMemWE_in,
  input  logic [DATA_W-1:0] reg1data_in,
  input  logic [DATA_W-1:0] reg2data_in,
  input  logic [4:0]        reg_write_addr_in,
  input  logic [4:0]        sa_in,
  input  logic [DATA_W-1:0] extended_data_in,
  output logic              stall_req,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [4:0]        reg_write_addr_out,
  output logic [1:0]        WriteDataSrc_out,
  output logic              DataMemWE_out,
  output logic              div_busy_out
);

  logic [DATA_W-1:0] opnd1, opnd2, alu_res;
  logic [DATA_W-1:0] quotient, remainder;
  logic              div_busy, div_done, div_accept;
  logic              cap_is_rem, cap_we;
  logic [4:0]        cap_addr;
  logic [1:0]        cap_wds;
  logic [DATA_W-1:0] cap_store;

  // Operand-1 select.
  always_comb begin
    opnd1 = '0;
    case (opnd1_sel_e'(ALUopnd1src_in))
      OPND1_REG: opnd1 = reg1data_in;
      OPND1_SA:  opnd1 = DATA_W'(sa_in);
      default:   opnd1 = '0;
    endcase
  end

  // Operand-2 select.
  always_comb begin
    opnd2 = '0;
    case (opnd2_sel_e'(ALUopnd2src_in))
      OPND2_REG:     opnd2 = reg2data_in;
      OPND2_EXT:     opnd2 = extended_data_in;
      OPND2_SIXTEEN: opnd2 = DATA_W'(16);
      default:       opnd2 = '0;
    endcase
  end

  // Single-cycle ALU; divide ops produce 0 here and are served by the divider.
  always_comb begin
    alu_res = '0;
    case (alu_op_e'(alu_op_in))
      ALU_OP_ADD:   alu_res = opnd1 + opnd2;
      ALU_OP_SUB:   alu_res = opnd1 - opnd2;
      ALU_OP_AND:   alu_res = opnd1 & opnd2;
      ALU_OP_OR:    alu_res = opnd1 | opnd2;
      ALU_OP_XOR:   alu_res = opnd1 ^ opnd2;
      ALU_OP_NOR:   alu_res = ~(opnd1 | opnd2);
      ALU_OP_SLL:   alu_res = opnd2 << opnd1[4:0];
      ALU_OP_SRL:   alu_res = opnd2 >> opnd1[4:0];
      ALU_OP_SRA:   alu_res = $signed(opnd2) >>> opnd1[4:0];
      ALU_OP_SLT:   alu_res = DATA_W'($signed(opnd1) < $signed(opnd2));
      ALU_OP_SLTU:  alu_res = DATA_W'(opnd1 < opnd2);
      ALU_OP_LUI:   alu_res = opnd2 << 16;
      ALU_OP_PASSB: alu_res = opnd2;
      default:      alu_res = '0;
    endcase
  end

  // A divide is accepted only while the divider is idle; stall covers the
  // accept cycle and all BUSY cycles, and depends only on state and op code.
  assign div_accept   = !div_busy && is_div_op(alu_op_in);
  assign stall_req    = div_accept || (div_busy && !div_done);
  assign div_busy_out = div_busy;

  div_iter_u #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_accept),
    .dividend  (opnd1),
    .divisor   (opnd2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Capture the divide's passthrough fields while the divider works.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_is_rem <= 1'b0;
      cap_we     <= 1'b0;
      cap_addr   <= INIT_5;
      cap_wds    <= WDATA_SRC_DEFAULT;
      cap_store  <= '0;
    end else if (div_accept) begin
      cap_is_rem <= (alu_op_in == ALU_OP_REMU);
      cap_we     <= DataMemWE_in;
      cap_addr   <= reg_write_addr_in;
      cap_wds    <= WriteDataSrc_in;
      cap_store  <= reg2data_in;
    end
  end

  // EXE/MEM register: divide result on DONE, bubble while a divide is
  // accepted or busy, otherwise the single-cycle ALU result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_out     <= '0;
      store_data_out     <= '0;
      reg_write_addr_out <= INIT_5;
      WriteDataSrc_out   <= WDATA_SRC_DEFAULT;
      DataMemWE_out      <= 1'b0;
    end else if (div_done) begin
      alu_result_out     <= cap_is_rem ? remainder : quotient;
      store_data_out     <= cap_store;
      reg_write_addr_out <= cap_addr;
      WriteDataSrc_out   <= cap_wds;
      DataMemWE_out      <= cap_we;
    end else if (div_accept || div_busy) begin
      alu_result_out     <= '0;
      store_data_out     <= '0;
      reg_write_addr_out <= INIT_5;
      WriteDataSrc_out   <= WDATA_SRC_DEFAULT;
      DataMemWE_out      <= 1'b0;
    end else begin
      alu_result_out     <= alu_res;
      store_data_out     <= reg2data_in;
      reg_write_addr_out <= reg_write_addr_in;
      WriteDataSrc_out   <= WriteDataSrc_in;
      DataMemWE_out      <= DataMemWE_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: scoreboard of expected EXE/MEM values,
// pushed when an instruction is driven and popped when it emerges.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_op_in;
  logic [1:0]  ALUopnd1src_in, ALUopnd2src_in, WriteDataSrc_in;
  logic        DataMemWE_in;
  logic [31:0] reg1data_in, reg2data_in, extended_data_in;
  logic [4:0]  reg_write_addr_in, sa_in;
  logic        stall_req, DataMemWE_out, div_busy_out;
  logic [31:0] alu_result_out, store_data_out;
  logic [4:0]  reg_write_addr_out;
  logic [1:0]  WriteDataSrc_out;

  typedef struct {
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  addr;
    logic [1:0]  wds;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  exe_stage dut (
    .clk                (clk),
    .rst                (rst),
    .alu_op_in          (alu_op_in),
    .ALUopnd1src_in     (ALUopnd1src_in),
    .ALUopnd2src_in     (ALUopnd2src_in),
    .WriteDataSrc_in    (WriteDataSrc_in),
    .DataMemWE_in       (DataMemWE_in),
    .reg1data_in        (reg1data_in),
    .reg2data_in        (reg2data_in),
    .reg_write_addr_in  (reg_write_addr_in),
    .sa_in              (sa_in),
    .extended_data_in   (extended_data_in),
    .stall_req          (stall_req),
    .alu_result_out     (alu_result_out),
    .store_data_out     (store_data_out),
    .reg_write_addr_out (reg_write_addr_out),
    .WriteDataSrc_out   (WriteDataSrc_out),
    .DataMemWE_out      (DataMemWE_out),
    .div_busy_out       (div_busy_out)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    alu_op_in         = 4'd15;
    ALUopnd1src_in    = 2'd0;
    ALUopnd2src_in    = 2'd0;
    WriteDataSrc_in   = 2'd0;
    DataMemWE_in      = 1'b0;
    reg1data_in       = 32'd0;
    reg2data_in       = 32'd0;
    extended_data_in  = 32'd0;
    reg_write_addr_in = 5'd0;
    sa_in             = 5'd0;
  endtask

  // One single-cycle instruction: drive, push expectation, pop after the edge.
  task automatic run_single(input string name, input logic [3:0] op,
                            input logic [1:0] s1, input logic [1:0] s2,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [4:0] sa, input logic [31:0] ext,
                            input logic [4:0] addr, input logic [1:0] wds,
                            input logic we, input logic [31:0] exp_res);
    exp_t e;
    alu_op_in = op; ALUopnd1src_in = s1; ALUopnd2src_in = s2;
    reg1data_in = r1; reg2data_in = r2; sa_in = sa; extended_data_in = ext;
    reg_write_addr_in = addr; WriteDataSrc_in = wds; DataMemWE_in = we;
    sb.push_back('{exp_res, r2, addr, wds, we});
    #1;
    n_assert++;
    if (stall_req !== 1'b0) begin
      n_fail++; $display("FAIL %s stall: got %b want 0", name, stall_req);
    end
    @(posedge clk); #1;
    idle_inputs();
    e = sb.pop_front();
    n_assert++;
    if (alu_result_out !== e.result || store_data_out !== e.store ||
        reg_write_addr_out !== e.addr || WriteDataSrc_out !== e.wds ||
        DataMemWE_out !== e.we) begin
      n_fail++;
      $display("FAIL %s: got res=%h st=%h a=%0d wds=%0d we=%b want res=%h st=%h a=%0d wds=%0d we=%b",
               name, alu_result_out, store_data_out, reg_write_addr_out, WriteDataSrc_out,
               DataMemWE_out, e.result, e.store, e.addr, e.wds, e.we);
    end
  endtask

  // One divide from accept to result; returns with the divider idle.
  task automatic do_div(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic [1:0] wds,
                        input logic we, input logic [31:0] exp_res);
    exp_t e;
    int   stall_cnt = 0;
    bit   bubble_bad = 0, busy_bad = 0, done_seen = 0;
    alu_op_in = op; ALUopnd1src_in = 2'd0; ALUopnd2src_in = 2'd0;
    reg1data_in = a; reg2data_in = b; reg_write_addr_in = dest;
    WriteDataSrc_in = wds; DataMemWE_in = we;
    sb.push_back('{exp_res, b, dest, wds, we});
    #1;
    n_assert++;
    if (stall_req !== 1'b1) begin
      n_fail++; $display("FAIL %s accept stall: got %b want 1", name, stall_req);
    end
    if (stall_req === 1'b1) stall_cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (alu_result_out !== 32'd0 || reg_write_addr_out !== 5'd0 ||
          DataMemWE_out !== 1'b0 || WriteDataSrc_out !== WDATA_SRC_DEFAULT)
        bubble_bad = 1;
      if (div_busy_out !== 1'b1) busy_bad = 1;
      if (stall_req === 1'b1) stall_cnt++;
      else begin
        done_seen = 1;
        break;
      end
    end
    n_assert++;
    if (!done_seen) begin
      n_fail++; $display("FAIL %s timeout: stall never dropped within 100 cycles", name);
    end
    n_assert++;
    if (stall_cnt != 33) begin
      n_fail++; $display("FAIL %s stall length: got %0d want 33", name, stall_cnt);
    end
    n_assert++;
    if (bubble_bad || busy_bad) begin
      n_fail++; $display("FAIL %s in-flight: bubble_bad=%0d busy_bad=%0d want 0 0", name, bubble_bad, busy_bad);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    n_assert++;
    if (alu_result_out !== e.result || store_data_out !== e.store ||
        reg_write_addr_out !== e.addr || WriteDataSrc_out !== e.wds ||
        DataMemWE_out !== e.we || div_busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: got res=%h st=%h a=%0d wds=%0d we=%b busy=%b want res=%h st=%h a=%0d wds=%0d we=%b busy=0",
               name, alu_result_out, store_data_out, reg_write_addr_out, WriteDataSrc_out,
               DataMemWE_out, div_busy_out, e.result, e.store, e.addr, e.wds, e.we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    n_assert++;
    if (alu_result_out !== 32'd0 || store_data_out !== 32'd0 || reg_write_addr_out !== 5'd0 ||
        WriteDataSrc_out !== WDATA_SRC_DEFAULT || DataMemWE_out !== 1'b0 ||
        stall_req !== 1'b0 || div_busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got res=%h st=%h a=%0d wds=%0d we=%b stall=%b busy=%b want all 0",
               alu_result_out, store_data_out, reg_write_addr_out, WriteDataSrc_out,
               DataMemWE_out, stall_req, div_busy_out);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    run_single("add_imm", 4'd0, 2'd0, 2'd1, 32'h5, 32'h0, 5'd0, 32'hFFFFFFFE, 5'd3, 2'd1, 1'b0, 32'h3);
    run_single("sra",     4'd8, 2'd1, 2'd0, 32'h0, 32'h80000000, 5'd4, 32'h0, 5'd4, 2'd0, 1'b0, 32'hF8000000);
    run_single("slt",     4'd9, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 5'd6, 2'd0, 1'b0, 32'h1);
    run_single("sltu",    4'd10, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 5'd7, 2'd0, 1'b0, 32'h0);
    run_single("sub",     4'd1, 2'd0, 2'd0, 32'h3, 32'h5, 5'd0, 32'h0, 5'd8, 2'd2, 1'b0, 32'hFFFFFFFE);
    run_single("lui",     4'd11, 2'd2, 2'd1, 32'h9, 32'h0, 5'd0, 32'h1234, 5'd9, 2'd0, 1'b0, 32'h12340000);
    run_single("sll_c16", 4'd6, 2'd0, 2'd2, 32'h4, 32'h0, 5'd0, 32'h0, 5'd10, 2'd0, 1'b0, 32'h100);
    run_single("srl",     4'd7, 2'd1, 2'd0, 32'h0, 32'h80000000, 5'd31, 32'h0, 5'd11, 2'd0, 1'b0, 32'h1);
    run_single("nor",     4'd5, 2'd0, 2'd0, 32'h0F0F0000, 32'h000000F0, 5'd0, 32'h0, 5'd12, 2'd0, 1'b0, 32'hF0F0FF0F);
    run_single("passb",   4'd14, 2'd0, 2'd1, 32'h1, 32'h0, 5'd0, 32'hCAFEF00D, 5'd13, 2'd3, 1'b0, 32'hCAFEF00D);
    run_single("nop",     4'd15, 2'd0, 2'd0, 32'h7, 32'h8, 5'd0, 32'h0, 5'd14, 2'd0, 1'b0, 32'h0);
  endtask

  task automatic test_store();
    run_single("store", 4'd0, 2'd0, 2'd1, 32'h100, 32'hDEADBEEF, 5'd0, 32'h8, 5'd0, 2'd0, 1'b1, 32'h108);
  endtask

  task automatic test_divide();
    logic [31:0] a, b;
    do_div("divu_100_7", 4'd12, 32'd100, 32'd7, 5'd5, 2'd1, 1'b0, 32'd14);
    @(posedge clk); #1;
    n_assert++;
    if (reg_write_addr_out !== 5'd0) begin
      n_fail++; $display("FAIL divu one-cycle dest: got %0d want 0", reg_write_addr_out);
    end
    do_div("remu_100_7", 4'd13, 32'd100, 32'd7, 5'd6, 2'd2, 1'b0, 32'd2);
    a = $urandom; b = $urandom_range(1, 1000);
    do_div("divu_rand", 4'd12, a, b, 5'd17, 2'd0, 1'b0, a / b);
    do_div("remu_rand", 4'd13, a, b, 5'd18, 2'd0, 1'b0, a % b);
  endtask

  task automatic test_div_zero();
    do_div("divu_zero", 4'd12, 32'h12345678, 32'd0, 5'd20, 2'd0, 1'b0, 32'hFFFFFFFF);
    do_div("remu_zero", 4'd13, 32'h12345678, 32'd0, 5'd21, 2'd0, 1'b0, 32'h12345678);
  endtask

  task automatic test_back_to_back();
    do_div("b2b_first",  4'd12, 32'd1000, 32'd10, 5'd22, 2'd1, 1'b0, 32'd100);
    do_div("b2b_second", 4'd13, 32'd1000, 32'd33, 5'd23, 2'd2, 1'b0, 32'd10);
    run_single("b2b_after", 4'd0, 2'd0, 2'd0, 32'd1, 32'd2, 5'd0, 32'h0, 5'd24, 2'd0, 1'b0, 32'd3);
  endtask

  task automatic test_reset_mid_div();
    alu_op_in = 4'd12; reg1data_in = 32'd500; reg2data_in = 32'd3; reg_write_addr_in = 5'd9;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      idle_inputs();
    end
    rst = 1'b1;
    #1;
    n_assert++;
    if (stall_req !== 1'b0 || div_busy_out !== 1'b0 || alu_result_out !== 32'd0 ||
        store_data_out !== 32'd0 || reg_write_addr_out !== 5'd0 ||
        WriteDataSrc_out !== WDATA_SRC_DEFAULT || DataMemWE_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_div_reset: got stall=%b busy=%b res=%h a=%0d want all 0",
               stall_req, div_busy_out, alu_result_out, reg_write_addr_out);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_single("add_after_reset", 4'd0, 2'd0, 2'd1, 32'h20, 32'h0, 5'd0, 32'h22, 5'd2, 2'd0, 1'b0, 32'h42);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_divide();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
